dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 20 ++
 rtl/dmem_timer.sv | 108 ++++++++++
 rtl/dmem_responder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder and its timer.
package dmem_pkg;

   // Word offsets of the peripheral registers inside the MMIO window
   localparam logic [3:0] OFF_LED   = 4'd0;
   localparam logic [3:0] OFF_CYCLE = 4'd1;
   localparam logic [3:0] OFF_CMP   = 4'd2;
   localparam logic [3:0] OFF_CTRL  = 4'd3;
   localparam logic [3:0] OFF_CNT   = 4'd4;

   // Bit positions inside the timer control register
   localparam int CTRL_EN      = 0;
   localparam int CTRL_IRQ     = 1;
   localparam int CTRL_ONESHOT = 2;

   // Compare value after reset: the longest possible period
   localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// DMEM port between the single-cycle core (master) and the responder (slave).
interface dmem_responder_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] DIR_DMEM;
   logic [31:0]       DATA_WRITE_DMEM;
   logic              READ;
   logic              WRITE;
   logic [31:0]       DATA_READ_DMEM;

   modport master (
      output DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
      input  DATA_READ_DMEM
   );

   modport slave (
      input  DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
      output DATA_READ_DMEM
   );
endinterface

// File: rtl/dmem_timer.sv
// Compare timer: IDLE/RUN/DONE state machine, counter, compare register and
// sticky match flag. Control register layout is {ONESHOT, IRQ, EN}.
module dmem_timer
   import dmem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmp_we,
   input  logic        ctrl_we,
   input  logic [31:0] wdata,
   output logic [31:0] cmp,
   output logic [2:0]  ctrl,
   output logic [31:0] cnt,
   output logic        irq
);

   timer_state_t state, state_next;
   logic [31:0]  cnt_next;
   logic         en, en_next;
   logic         oneshot, oneshot_next;
   logic         irq_next;
   logic         match_set;
   logic         oneshot_hit;

   // State, counter and control registers; a compare write lands at the edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         cmp     <= CMP_RESET;
         en      <= 1'b0;
         oneshot <= 1'b0;
         irq     <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         en      <= en_next;
         oneshot <= oneshot_next;
         irq     <= irq_next;
         if (cmp_we) begin
            cmp <= wdata;
         end
      end
   end

   // Next state and counter; a match sets IRQ, and one-shot match drops EN,
   // which outranks a software EN write and an IRQ write-one-to-clear
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      match_set   = 1'b0;
      oneshot_hit = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (en) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == cmp) begin
               match_set = 1'b1;
               cnt_next  = '0;
               if (oneshot) begin
                  state_next  = DONE;
                  oneshot_hit = 1'b1;
               end
            end else begin
               cnt_next = cnt + 32'd1;
            end
         end
         DONE: begin
            cnt_next = '0;
            if (en) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      en_next = en;
      if (ctrl_we) begin
         en_next = wdata[CTRL_EN];
      end
      if (oneshot_hit) begin
         en_next = 1'b0;
      end

      oneshot_next = ctrl_we ? wdata[CTRL_ONESHOT] : oneshot;

      irq_next = irq;
      if (ctrl_we && wdata[CTRL_IRQ]) begin
         irq_next = 1'b0;
      end
      if (match_set) begin
         irq_next = 1'b1;
      end
   end

   assign ctrl = {oneshot, irq, en};

endmodule

// File: rtl/dmem_responder.sv
// Far end of the core's DMEM port: word RAM below MMIO_BASE and a 16-word
// peripheral window (LED, cycle counter, optional compare timer) above it.
// Loads are combinational; everything else updates on the rising edge.
// Defining DMEM_TIMER_EN builds the compare timer; without it offsets 2..4
// are reserved and TIMER_IRQ stays low.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] MMIO_BASE = 10'h3F0,
   parameter int                LED_W     = 8
)(
   input  logic             CLK,
   input  logic             RESET,
   dmem_responder_if.slave  bus,
   output logic [LED_W-1:0] LEDS,
   output logic             TIMER_IRQ,
   output logic             ACCESS_ERR
);

   logic [31:0]       ram [0:MMIO_BASE-1];
   logic [LED_W-1:0]  led_q;
   logic [31:0]       cycle_q;
   logic              err_next;
   logic [31:0]       rdata;

   logic [ADDR_W-1:0] rel_addr;
   logic [3:0]        off;
   logic              is_ram, in_window;
   logic              sel_led, sel_cycle, sel_cmp, sel_ctrl, sel_cnt;
   logic              reserved, read_only;

   logic [31:0]       timer_cmp;
   logic [2:0]        timer_ctrl;
   logic [31:0]       timer_cnt;
   logic              timer_irq;

   assign is_ram    = bus.DIR_DMEM < MMIO_BASE;
   assign rel_addr  = bus.DIR_DMEM - MMIO_BASE;
   assign off       = rel_addr[3:0];
   assign in_window = !is_ram && (rel_addr[ADDR_W-1:4] == '0);

   assign sel_led   = in_window && (off == OFF_LED);
   assign sel_cycle = in_window && (off == OFF_CYCLE);

`ifdef DMEM_TIMER_EN
   assign sel_cmp  = in_window && (off == OFF_CMP);
   assign sel_ctrl = in_window && (off == OFF_CTRL);
   assign sel_cnt  = in_window && (off == OFF_CNT);

   dmem_timer u_timer (
      .clk     (CLK),
      .reset   (RESET),
      .cmp_we  (bus.WRITE && sel_cmp),
      .ctrl_we (bus.WRITE && sel_ctrl),
      .wdata   (bus.DATA_WRITE_DMEM),
      .cmp     (timer_cmp),
      .ctrl    (timer_ctrl),
      .cnt     (timer_cnt),
      .irq     (timer_irq)
   );
`else
   assign sel_cmp    = 1'b0;
   assign sel_ctrl   = 1'b0;
   assign sel_cnt    = 1'b0;
   assign timer_cmp  = '0;
   assign timer_ctrl = '0;
   assign timer_cnt  = '0;
   assign timer_irq  = 1'b0;
`endif

   assign reserved  = !is_ram && !(sel_led || sel_cycle || sel_cmp || sel_ctrl || sel_cnt);
   assign read_only = sel_cycle || sel_cnt;

   // RAM store path; not reset, so a store in a reset cycle still lands
   always_ff @(posedge CLK) begin
      if (bus.WRITE && is_ram) begin
         ram[bus.DIR_DMEM] <= bus.DATA_WRITE_DMEM;
      end
   end

   // LED register, writable in its low LED_W bits
   always_ff @(posedge CLK) begin
      if (RESET) begin
         led_q <= '0;
      end else if (bus.WRITE && sel_led) begin
         led_q <= bus.DATA_WRITE_DMEM[LED_W-1:0];
      end
   end

   // Free-running cycle counter, wraps naturally at 2^32
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   // Error pulse for bad writes, reserved reads and simultaneous strobes
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ACCESS_ERR <= 1'b0;
      end else begin
         ACCESS_ERR <= err_next;
      end
   end

   assign err_next = (bus.WRITE && (reserved || read_only)) ||
                     (bus.READ && reserved) ||
                     (bus.READ && bus.WRITE);

   // Combinational load mux; zero when READ is low or address is reserved
   always_comb begin
      rdata = '0;
      if (bus.READ) begin
         if (is_ram) begin
            rdata = ram[bus.DIR_DMEM];
         end else if (sel_led) begin
            rdata = 32'(led_q);
         end else if (sel_cycle) begin
            rdata = cycle_q;
         end else if (sel_cmp) begin
            rdata = timer_cmp;
         end else if (sel_ctrl) begin
            rdata = 32'(timer_ctrl);
         end else if (sel_cnt) begin
            rdata = timer_cnt;
         end
      end
   end

   assign bus.DATA_READ_DMEM = rdata;
   assign LEDS               = led_q;
   assign TIMER_IRQ          = timer_irq;

endmodule
